cache_fill_ctrl: RTL and testbench

Sequencing controller for the 32-entry associative lookup store (shift-in {addr,data} array with combinational FOUND/DOUT). It accepts one CPU load/store at a time, probes the lookup store, and serves hits directly. On a read miss it fetches from backing memory and shifts the line in. Stores are write-through and are also shifted in; the youngest entry shadows older ones.

---
 rtl/cache_fill_ctrl.sv | 172 +++++++++++++++++
 tb/tb_cache_fill_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_ctrl.sv
// Load/store sequencer in front of a shift-in associative lookup store with write-through backing memory.
// Optional load hit/miss counters are built only when CACHE_STATS_EN is defined.
module cache_fill_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    // CPU side: a request is taken on any edge where CPU_REQ=1 and CPU_READY=1;
    // CPU_VALID is a one-cycle strobe, qualified by CPU_ERR.
    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [DATA_W-1:0] CPU_WDATA,
    output logic              CPU_READY,
    output logic              CPU_VALID,
    output logic [DATA_W-1:0] CPU_RDATA,
    output logic              CPU_ERR,
    output logic [ADDR_W-1:0] LK_ADDR,
    output logic [DATA_W-1:0] LK_DIN,
    output logic              LK_WE,
    input  logic [DATA_W-1:0] LK_DOUT,
    input  logic              LK_FOUND,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic              MEM_ACK,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic [31:0]       HIT_CNT,
    output logic [31:0]       MISS_CNT,
    output logic [2:0]        DBG_STATE
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_MEM    = 3'd2,
        S_FILL   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    localparam logic [15:0] TMO = 16'(TIMEOUT);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              addr_zero;
    logic              lk_hit;

    // Address 0 collides with never-written (zeroed) entries, so it is never cached.
    assign addr_zero = (addr_q == '0);
    assign lk_hit    = LK_FOUND && !addr_zero;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (CPU_REQ) begin
                    addr_d  = CPU_ADDR;
                    we_d    = CPU_WE;
                    wdata_d = CPU_WDATA;
                    cnt_d   = '0;
                    state_d = CPU_WE ? S_MEM : S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (lk_hit) begin
                    rdata_d = LK_DOUT;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = S_MEM;
                end
            end
            S_MEM: begin
                // An ack in the final allowed cycle still wins over the timeout.
                if (MEM_ACK) begin
                    if (!we_q) begin
                        rdata_d = MEM_RDATA;
                    end
                    state_d = S_FILL;
                end else if (cnt_q == TMO) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_FILL: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Loads fill with the captured memory word, which also sits in rdata_q.
    assign CPU_READY = (state_q == S_IDLE);
    assign CPU_VALID = (state_q == S_RESP);
    assign CPU_RDATA = rdata_q;
    assign CPU_ERR   = err_q;
    assign LK_ADDR   = addr_q;
    assign LK_DIN    = we_q ? wdata_q : rdata_q;
    assign LK_WE     = (state_q == S_FILL) && !addr_zero;
    assign MEM_REQ   = (state_q == S_MEM);
    assign MEM_WE    = (state_q == S_MEM) && we_q;
    assign MEM_ADDR  = addr_q;
    assign MEM_WDATA = wdata_q;
    assign DBG_STATE = state_q;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == S_LOOKUP) begin
            if (lk_hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign HIT_CNT  = hit_cnt_q;
    assign MISS_CNT = miss_cnt_q;
`else
    assign HIT_CNT  = '0;
    assign MISS_CNT = '0;
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl with a behavioural 32-entry shift-in lookup store.
module tb_cache_fill_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
`ifdef CACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic          CPU_REQ, CPU_WE;
    logic [AW-1:0] CPU_ADDR;
    logic [DW-1:0] CPU_WDATA;
    logic          CPU_READY, CPU_VALID, CPU_ERR;
    logic [DW-1:0] CPU_RDATA;
    logic [AW-1:0] LK_ADDR;
    logic [DW-1:0] LK_DIN, LK_DOUT;
    logic          LK_WE, LK_FOUND;
    logic          MEM_REQ, MEM_WE, MEM_ACK;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_WDATA, MEM_RDATA;
    logic [31:0]   HIT_CNT, MISS_CNT;
    logic [2:0]    DBG_STATE;

    int checks = 0;
    int fails  = 0;

    int            t_req_cyc;
    logic          t_mem_we;
    logic [AW-1:0] t_mem_addr;
    logic [DW-1:0] t_mem_wdata;
    int            t_lk_we;
    logic [AW-1:0] t_lk_addr;
    logic [DW-1:0] t_lk_din;
    int            vcyc;
    logic          verr;
    logic [DW-1:0] vdata;

    always #5 CLK = ~CLK;

    cache_fill_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
        .CPU_READY(CPU_READY), .CPU_VALID(CPU_VALID), .CPU_RDATA(CPU_RDATA), .CPU_ERR(CPU_ERR),
        .LK_ADDR(LK_ADDR), .LK_DIN(LK_DIN), .LK_WE(LK_WE), .LK_DOUT(LK_DOUT), .LK_FOUND(LK_FOUND),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
        .HIT_CNT(HIT_CNT), .MISS_CNT(MISS_CNT), .DBG_STATE(DBG_STATE)
    );

    // Lookup store model: entry 0 is youngest; zeroed entries match key 0.
    logic [AW-1:0] lk_key [32];
    logic [DW-1:0] lk_dat [32];

    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 32; i++) begin
                lk_key[i] <= '0;
                lk_dat[i] <= '0;
            end
        end else if (LK_WE) begin
            for (int i = 31; i > 0; i--) begin
                lk_key[i] <= lk_key[i-1];
                lk_dat[i] <= lk_dat[i-1];
            end
            lk_key[0] <= LK_ADDR;
            lk_dat[0] <= LK_DIN;
        end
    end

    always_comb begin
        LK_FOUND = 1'b0;
        LK_DOUT  = '0;
        for (int i = 31; i >= 0; i--) begin
            if (lk_key[i] == LK_ADDR) begin
                LK_FOUND = 1'b1;
                LK_DOUT  = lk_dat[i];
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Cycle 0 is the cycle the request is presented; memory acks in cycle ack_cyc (-1 = never).
    task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int ack_cyc, input logic [DW-1:0] mdata);
        t_req_cyc = 0; t_mem_we = 1'b0; t_mem_addr = '0; t_mem_wdata = '0;
        t_lk_we = 0; t_lk_addr = '0; t_lk_din = '0;
        vcyc = -1; verr = 1'b0; vdata = '0;
        CPU_REQ = 1'b1; CPU_WE = we; CPU_ADDR = addr; CPU_WDATA = wdata;
        for (int c = 0; c < 40; c++) begin
            if (c > 0 && CPU_VALID) begin
                vcyc = c; verr = CPU_ERR; vdata = CPU_RDATA;
                break;
            end
            if (MEM_REQ) begin
                t_req_cyc++; t_mem_we = MEM_WE; t_mem_addr = MEM_ADDR; t_mem_wdata = MEM_WDATA;
            end
            if (LK_WE) begin
                t_lk_we++; t_lk_addr = LK_ADDR; t_lk_din = LK_DIN;
            end
            MEM_ACK   = (c == ack_cyc);
            MEM_RDATA = (c == ack_cyc) ? mdata : 32'h0BAD_0BAD;
            tick();
            CPU_REQ = 1'b0;
        end
        MEM_ACK = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_WDATA = '0;
        MEM_ACK = 1'b0; MEM_RDATA = '0;
        repeat (3) tick();
        RST = 1'b0;
        tick();
        checks++;
        if ({CPU_READY, CPU_VALID, CPU_ERR, LK_WE, MEM_REQ, MEM_WE} !== 6'b100000) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 100000", {CPU_READY, CPU_VALID, CPU_ERR, LK_WE, MEM_REQ, MEM_WE});
        end
        checks++;
        if ({CPU_RDATA, LK_ADDR, LK_DIN, MEM_ADDR, MEM_WDATA} !== 160'h0) begin
            fails++;
            $display("FAIL reset_data: rdata=%h lk_addr=%h lk_din=%h mem_addr=%h mem_wdata=%h expected all 0",
                     CPU_RDATA, LK_ADDR, LK_DIN, MEM_ADDR, MEM_WDATA);
        end
        checks++;
        if (HIT_CNT !== 32'd0 || MISS_CNT !== 32'd0 || DBG_STATE !== 3'd0) begin
            fails++;
            $display("FAIL reset_cnt: hit=%0d miss=%0d state=%0d expected 0 0 0", HIT_CNT, MISS_CNT, DBG_STATE);
        end
    endtask

    task automatic test_load_miss();
        run_txn(1'b0, 32'h100, '0, 5, 32'hDEAD_BEEF);
        checks++;
        if (vcyc !== 7 || verr !== 1'b0 || vdata !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL miss_resp: cyc=%0d err=%b data=%h expected 7 0 deadbeef", vcyc, verr, vdata);
        end
        checks++;
        if (t_req_cyc !== 4 || t_mem_we !== 1'b0 || t_mem_addr !== 32'h100) begin
            fails++;
            $display("FAIL miss_mem: req_cycles=%0d we=%b addr=%h expected 4 0 100", t_req_cyc, t_mem_we, t_mem_addr);
        end
        checks++;
        if (t_lk_we !== 1 || t_lk_din !== 32'hDEAD_BEEF || t_lk_addr !== 32'h100) begin
            fails++;
            $display("FAIL miss_fill: we_pulses=%0d din=%h addr=%h expected 1 deadbeef 100", t_lk_we, t_lk_din, t_lk_addr);
        end
        checks++;
        if (MISS_CNT !== (STATS ? 32'd1 : 32'd0)) begin
            fails++;
            $display("FAIL miss_cnt: got %0d expected %0d", MISS_CNT, STATS ? 1 : 0);
        end
        tick();
        checks++;
        if (CPU_READY !== 1'b1 || CPU_VALID !== 1'b0) begin
            fails++;
            $display("FAIL miss_idle: ready=%b valid=%b expected 1 0", CPU_READY, CPU_VALID);
        end
    endtask

    task automatic test_load_hit();
        run_txn(1'b0, 32'h100, '0, -1, '0);
        checks++;
        if (vcyc !== 2 || verr !== 1'b0 || vdata !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL hit_resp: cyc=%0d err=%b data=%h expected 2 0 deadbeef", vcyc, verr, vdata);
        end
        checks++;
        if (t_req_cyc !== 0 || t_lk_we !== 0) begin
            fails++;
            $display("FAIL hit_side: req_cycles=%0d lk_we=%0d expected 0 0", t_req_cyc, t_lk_we);
        end
        checks++;
        if (HIT_CNT !== (STATS ? 32'd1 : 32'd0)) begin
            fails++;
            $display("FAIL hit_cnt: got %0d expected %0d", HIT_CNT, STATS ? 1 : 0);
        end
        tick();
    endtask

    task automatic test_store_shadow();
        run_txn(1'b1, 32'h100, 32'h1234_5678, 3, '0);
        checks++;
        if (vcyc !== 5 || verr !== 1'b0 || vdata !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL store_resp: cyc=%0d err=%b rdata=%h expected 5 0 deadbeef", vcyc, verr, vdata);
        end
        checks++;
        if (t_req_cyc !== 3 || t_mem_we !== 1'b1 || t_mem_wdata !== 32'h1234_5678) begin
            fails++;
            $display("FAIL store_mem: req_cycles=%0d we=%b wdata=%h expected 3 1 12345678", t_req_cyc, t_mem_we, t_mem_wdata);
        end
        checks++;
        if (t_lk_we !== 1 || t_lk_din !== 32'h1234_5678) begin
            fails++;
            $display("FAIL store_fill: we_pulses=%0d din=%h expected 1 12345678", t_lk_we, t_lk_din);
        end
        tick();
        run_txn(1'b0, 32'h100, '0, -1, '0);
        checks++;
        if (vcyc !== 2 || vdata !== 32'h1234_5678 || t_req_cyc !== 0) begin
            fails++;
            $display("FAIL store_shadow: cyc=%0d data=%h req_cycles=%0d expected 2 12345678 0", vcyc, vdata, t_req_cyc);
        end
        checks++;
        if (HIT_CNT !== (STATS ? 32'd2 : 32'd0)) begin
            fails++;
            $display("FAIL shadow_cnt: got %0d expected %0d", HIT_CNT, STATS ? 2 : 0);
        end
        tick();
    endtask

    task automatic test_addr_zero();
        run_txn(1'b0, 32'h0, '0, 2, 32'hCAFE_F00D);
        checks++;
        if (vcyc !== 4 || verr !== 1'b0 || vdata !== 32'hCAFE_F00D) begin
            fails++;
            $display("FAIL zero_resp: cyc=%0d err=%b data=%h expected 4 0 cafef00d", vcyc, verr, vdata);
        end
        checks++;
        if (t_req_cyc !== 1 || t_lk_we !== 0) begin
            fails++;
            $display("FAIL zero_side: req_cycles=%0d lk_we=%0d expected 1 0", t_req_cyc, t_lk_we);
        end
        checks++;
        if (MISS_CNT !== (STATS ? 32'd2 : 32'd0)) begin
            fails++;
            $display("FAIL zero_cnt: got %0d expected %0d", MISS_CNT, STATS ? 2 : 0);
        end
        tick();
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 32'h200, '0, -1, '0);
        checks++;
        if (vcyc !== 7 || verr !== 1'b1) begin
            fails++;
            $display("FAIL tmo_resp: cyc=%0d err=%b expected 7 1", vcyc, verr);
        end
        checks++;
        if (t_req_cyc !== 5 || t_lk_we !== 0) begin
            fails++;
            $display("FAIL tmo_side: req_cycles=%0d lk_we=%0d expected 5 0", t_req_cyc, t_lk_we);
        end
        tick();
        checks++;
        if (CPU_READY !== 1'b1 || CPU_ERR !== 1'b0 || CPU_VALID !== 1'b0) begin
            fails++;
            $display("FAIL tmo_after: ready=%b err=%b valid=%b expected 1 0 0", CPU_READY, CPU_ERR, CPU_VALID);
        end
    endtask

    task automatic test_ack_at_timeout();
        run_txn(1'b1, 32'h300, 32'h0000_0300, 5, '0);
        checks++;
        if (vcyc !== 7 || verr !== 1'b0 || t_lk_we !== 1 || t_req_cyc !== 5) begin
            fails++;
            $display("FAIL ack_edge: cyc=%0d err=%b lk_we=%0d req_cycles=%0d expected 7 0 1 5", vcyc, verr, t_lk_we, t_req_cyc);
        end
        tick();
    endtask

    task automatic test_reset_in_mem();
        CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 32'h400; CPU_WDATA = '0;
        tick();
        CPU_REQ = 1'b0;
        tick();
        tick();
        checks++;
        if (MEM_REQ !== 1'b1) begin
            fails++;
            $display("FAIL rst_pre: mem_req=%b expected 1", MEM_REQ);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if (MEM_REQ !== 1'b0 || CPU_READY !== 1'b1 || LK_WE !== 1'b0) begin
            fails++;
            $display("FAIL rst_mem: mem_req=%b ready=%b lk_we=%b expected 0 1 0", MEM_REQ, CPU_READY, LK_WE);
        end
        MEM_ACK = 1'b1; MEM_RDATA = 32'h7777_7777;
        tick();
        MEM_ACK = 1'b0;
        checks++;
        if (CPU_READY !== 1'b1 || CPU_VALID !== 1'b0 || LK_WE !== 1'b0 || MEM_REQ !== 1'b0) begin
            fails++;
            $display("FAIL late_ack: ready=%b valid=%b lk_we=%b mem_req=%b expected 1 0 0 0",
                     CPU_READY, CPU_VALID, LK_WE, MEM_REQ);
        end
        checks++;
        if (HIT_CNT !== 32'd0 || MISS_CNT !== 32'd0) begin
            fails++;
            $display("FAIL rst_cnt: hit=%0d miss=%0d expected 0 0", HIT_CNT, MISS_CNT);
        end
        run_txn(1'b0, 32'h500, '0, 2, 32'h0000_55AA);
        checks++;
        if (vcyc !== 4 || verr !== 1'b0 || vdata !== 32'h0000_55AA || t_lk_we !== 1) begin
            fails++;
            $display("FAIL rst_resume: cyc=%0d err=%b data=%h lk_we=%0d expected 4 0 000055aa 1",
                     vcyc, verr, vdata, t_lk_we);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_load_miss();
        test_load_hit();
        test_store_shadow();
        test_addr_zero();
        test_timeout();
        test_ack_at_timeout();
        test_reset_in_mem();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
